imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Sequences the single-port instruction memory between boot-time program load and core fetch.
//  Receives a byte stream (valid/ready), packs it little-endian into 32-bit words, writes them to
//  consecutive word addresses from 0, then hands the memory address port to the core's PC.
//  Sits between the byte source (UART/debug), the instruction memory and the fetch stage.
//  Holds the core stalled and feeds it NOPs until the load completes.
// PARAMETERS
//  ADDR_W    6             word-address width; memory depth = 2**ADDR_W words (64)
//  NOP_INSTR 32'h00000013  instruction presented to the core while stalled (addi x0,x0,0)
// PORTS
//  clk          in   1         system clock, all state on rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  start        in   1         single-cycle pulse: begin a load of word_count words
//  word_count   in   ADDR_W+1  number of words to load (0..2**ADDR_W), sampled with start
//  byte_valid   in   1         byte_data is valid
//  byte_data    in   8         program byte, little-endian within each word
//  byte_ready   out  1         loader accepts a byte this cycle
//  fetch_addr   in   32        byte address from the PC
//  mem_rdata    in   32        instruction read from memory (combinational read)
//  mem_addr     out  ADDR_W    word address to memory (write index or fetch_addr[ADDR_W+1:2])
//  mem_we       out  1         memory write strobe, one cycle per word
//  mem_wdata    out  32        assembled word
//  instr_out    out  32        instruction to core: NOP_INSTR when core_stall, else mem_rdata
//  core_stall   out  1         holds PC/core while not in RUN
//  load_done    out  1         high in RUN after a load (or a zero-length start)
//  load_err     out  1         sticky: start with word_count > 2**ADDR_W
//  addr_fault   out  1         RUN and fetch_addr[31:ADDR_W+2] != 0 (combinational)
// BEHAVIOUR
//  Reset: state=IDLE, byte_ready=0, mem_we=0, mem_wdata=0, core_stall=1, load_done=0, load_err=0,
//   byte index=0, word index=0, word target=0. Reset mid-load discards partial bytes; words already
//   written stay in memory.
//  FSM IDLE -> LOAD -> WRITE -> LOAD/RUN; RUN -> LOAD on start.
//  IDLE: start & 1<=word_count<=2**ADDR_W -> LOAD, latch target, clear load_err.
//   start & word_count==0 -> RUN (boot existing image). start & word_count>2**ADDR_W -> stay IDLE,
//   load_err=1 until the next accepted start.
//  LOAD: byte_ready=1. Transfer on byte_valid&byte_ready; byte k (0..3) -> wdata[8k+7:8k].
//   Transfer of byte 3 -> WRITE. No transfer -> hold, no timeout.
//  WRITE (exactly 1 cycle): mem_we=1, mem_addr=word index, byte_ready=0. Then word index+1.
//   Next state LOAD if words written < target, else RUN.
//  Throughput: 4 bytes + 1 write cycle per word, 5 cycles minimum per word.
//  RUN: core_stall=0, load_done=1, mem_addr=fetch_addr[ADDR_W+1:2]; fetch_addr[1:0] ignored.
//   start in RUN -> LOAD (reload): core_stall=1 and load_done=0 from the next cycle.
//  start in LOAD/WRITE is ignored. In IDLE/LOAD/WRITE mem_addr = word index.
//  The word index never wraps: target <= 2**ADDR_W bounds it.
//  Outputs are registered except instr_out, mem_addr in RUN, and addr_fault.
// TESTING
//  Reset, no start -> core_stall=1, instr_out=32'h00000013, byte_ready=0, mem_we=0 indefinitely.
//  start, word_count=2; bytes 13 04 50 00 93 04 30 00 back-to-back -> mem_we at word0=32'h00500413,
//   word1=32'h00300493, each 1 cycle after the 4th byte; RUN and load_done=1 after 2nd write.
//  Same load with byte_valid toggled 1/0 -> identical writes, bytes never lost or duplicated.
//  start, word_count=65 -> load_err=1, stays IDLE; then start, word_count=0 -> RUN, load_err=0.
//  rst_n low after 2 bytes of word 1 -> all outputs at reset values asynchronously; word0 untouched.
//  RUN, fetch_addr=32'h0000003C -> mem_addr=15; fetch_addr=32'h00000100 -> addr_fault=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Owns the instruction-memory address port during boot. A byte stream
//   (valid/ready) is packed little-endian into 32-bit words that are written to
//   consecutive word addresses starting at 0. Once the requested number of words
//   has been written, the address port is handed over to the core's PC and the
//   core is released from stall. Until then the core sees NOP_INSTR.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   start        one-cycle pulse: begin a load of word_count words
//   word_count   words to load (0..2**ADDR_W), sampled with start
//   byte_valid   byte_data valid
//   byte_data    program byte, little-endian within each word
//   byte_ready   loader accepts a byte this cycle
//   fetch_addr   byte address from the PC
//   mem_rdata    combinational read data from the instruction memory
//   mem_addr     word address: write index while loading, PC word address in RUN
//   mem_we       one-cycle write strobe per assembled word
//   mem_wdata    assembled word
//   instr_out    instruction to core (NOP_INSTR while stalled)
//   core_stall   holds the core while not in RUN
//   load_done    high in RUN after a load or a zero-length start
//   load_err     sticky: start with word_count > 2**ADDR_W
//   addr_fault   RUN and fetch_addr outside the memory (combinational)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, core stalled, waiting for a valid start
// LOAD  | accepting bytes of the current word (byte_ready = 1)
// WRITE | one-cycle memory write of the assembled word
// RUN   | core owns the address port; start triggers a reload

module imem_boot_loader #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [31:0]       fetch_addr,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       instr_out,
    output logic              core_stall,
    output logic              load_done,
    output logic              load_err,
    output logic              addr_fault
);

    localparam int            DEPTH_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH = DEPTH_I[ADDR_W:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        byte_idx;
    // One bit wider than the address so a full-depth target is representable;
    // the target bound keeps the index itself below DEPTH.
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W:0]   word_tgt;
    logic [ADDR_W:0]   word_idx_nxt;

    assign word_idx_nxt = word_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_idx   <= 2'd0;
            word_idx   <= '0;
            word_tgt   <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 32'd0;
            core_stall <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RUN: begin
                    // A start is decoded the same way from IDLE and RUN; an
                    // oversized count leaves the current state untouched.
                    if (start) begin
                        if (word_count == '0) begin
                            state      <= S_RUN;
                            core_stall <= 1'b0;
                            load_done  <= 1'b1;
                            load_err   <= 1'b0;
                        end else if (word_count <= DEPTH) begin
                            state      <= S_LOAD;
                            word_tgt   <= word_count;
                            word_idx   <= '0;
                            byte_idx   <= 2'd0;
                            byte_ready <= 1'b1;
                            core_stall <= 1'b1;
                            load_done  <= 1'b0;
                            load_err   <= 1'b0;
                        end else begin
                            load_err   <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (byte_valid && byte_ready) begin
                        mem_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    mem_we   <= 1'b0;
                    word_idx <= word_idx_nxt;
                    if (word_idx_nxt < word_tgt) begin
                        state      <= S_LOAD;
                        byte_ready <= 1'b1;
                    end else begin
                        state      <= S_RUN;
                        core_stall <= 1'b0;
                        load_done  <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Word-aligned fetch: the two byte-offset bits are deliberately dropped.
    logic unused_fetch_lsb;
    assign unused_fetch_lsb = ^fetch_addr[1:0];

    assign mem_addr   = (state == S_RUN) ? fetch_addr[ADDR_W+1:2] : word_idx[ADDR_W-1:0];
    assign instr_out  = core_stall ? NOP_INSTR : mem_rdata;
    assign addr_fault = (state == S_RUN) && (fetch_addr[31:ADDR_W+2] != '0);

endmodule
